// File: rtl/riscv_tag_prop_ex.sv
// Tag propagation EX stage: computes a one-bit result tag per instruction and emits a tag RF write.
// Latency: result valid one cycle after accept (or one cycle after ex_done for multicycle ops).
// Backpressure: holds result stable while wb_ready_i is low; ex_ready_o is low in HOLD and in OUT without wb_ready_i.
module riscv_tag_prop_ex #(
  parameter int ALU_MODE_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid_i,
  output logic                      ex_ready_o,
  input  logic [ALU_MODE_WIDTH-1:0] mode_i,
  input  logic                      register_set_i,
  input  logic                      set_tag_i,
  input  logic                      rs1_tag_i,
  input  logic                      rs2_tag_i,
  input  logic                      use_rs2_i,
  input  logic                      rd_tag_old_i,
  input  logic [4:0]                rd_addr_i,
  input  logic                      rd_we_i,
  input  logic                      multicycle_i,
  input  logic                      ex_done_i,
  input  logic                      flush_i,
  input  logic                      wb_ready_i,
  output logic                      res_valid_o,
  output logic                      tag_we_o,
  output logic [4:0]                tag_waddr_o,
  output logic                      tag_wdata_o,
  input  logic                      cnt_clr_i,
  output logic [15:0]               taint_cnt_o
);

  localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_OLD   = ALU_MODE_WIDTH'(0);
  localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_AND   = ALU_MODE_WIDTH'(1);
  localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_OR    = ALU_MODE_WIDTH'(2);
  localparam logic [ALU_MODE_WIDTH-1:0] ALU_MODE_CLEAR = ALU_MODE_WIDTH'(3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        accept;
  logic        complete;
  logic        tag_calc;
  logic        rd_we_q;
  logic [4:0]  rd_addr_q;
  logic        tag_q;

  assign ex_ready_o  = (state == IDLE) | ((state == OUT) & wb_ready_i);
  assign accept      = id_valid_i & ex_ready_o & ~flush_i;
  assign res_valid_o = (state == OUT);
  assign complete    = res_valid_o & wb_ready_i;
  assign tag_waddr_o = rd_addr_q;
  assign tag_wdata_o = tag_q;
  assign tag_we_o    = res_valid_o & rd_we_q & (rd_addr_q != 5'd0);

  // Result tag from the ID-stage operands; an explicit tag-set beats any mode.
  always_comb begin
    tag_calc = rd_tag_old_i;
    if (register_set_i) begin
      tag_calc = set_tag_i;
    end else begin
      case (mode_i)
        ALU_MODE_OLD:   tag_calc = rd_tag_old_i;
        ALU_MODE_AND:   tag_calc = rs1_tag_i & (use_rs2_i ? rs2_tag_i : 1'b1);
        ALU_MODE_OR:    tag_calc = rs1_tag_i | (use_rs2_i ? rs2_tag_i : 1'b0);
        ALU_MODE_CLEAR: tag_calc = 1'b0;
        default:        tag_calc = rd_tag_old_i;
      endcase
    end
  end

  // Next-state logic; flush overrides accept and completion.
  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state_nxt = multicycle_i ? HOLD : OUT;
        HOLD: if (ex_done_i) state_nxt = OUT;
        OUT: begin
          if (wb_ready_i) begin
            if (accept) state_nxt = multicycle_i ? HOLD : OUT;
            else        state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture destination and result tag on accept; held otherwise so outputs stay stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_we_q   <= 1'b0;
      rd_addr_q <= 5'd0;
      tag_q     <= 1'b0;
    end else if (accept) begin
      rd_we_q   <= rd_we_i;
      rd_addr_q <= rd_addr_i;
      tag_q     <= tag_calc;
    end
  end

  // Saturating count of tainted writes that actually complete; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      taint_cnt_o <= 16'd0;
    end else if (cnt_clr_i) begin
      taint_cnt_o <= 16'd0;
    end else if (complete & ~flush_i & tag_we_o & tag_wdata_o & (taint_cnt_o != 16'hFFFF)) begin
      taint_cnt_o <= taint_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_riscv_tag_prop_ex.sv
// Directed bench for riscv_tag_prop_ex: vector table for the tag function plus sequences for timing corners.
// Inputs change 1ns after the rising edge; outputs are sampled 2ns after the edge.
module tb_riscv_tag_prop_ex;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [1:0]  mode_i = 2'b00;
  logic        register_set_i = 1'b0;
  logic        set_tag_i = 1'b0;
  logic        rs1_tag_i = 1'b0;
  logic        rs2_tag_i = 1'b0;
  logic        use_rs2_i = 1'b0;
  logic        rd_tag_old_i = 1'b0;
  logic [4:0]  rd_addr_i = 5'd0;
  logic        rd_we_i = 1'b0;
  logic        multicycle_i = 1'b0;
  logic        ex_done_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        wb_ready_i = 1'b1;
  logic        res_valid_o;
  logic        tag_we_o;
  logic [4:0]  tag_waddr_o;
  logic        tag_wdata_o;
  logic        cnt_clr_i = 1'b0;
  logic [15:0] taint_cnt_o;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  riscv_tag_prop_ex #(.ALU_MODE_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .ex_ready_o(ex_ready_o),
    .mode_i(mode_i), .register_set_i(register_set_i), .set_tag_i(set_tag_i),
    .rs1_tag_i(rs1_tag_i), .rs2_tag_i(rs2_tag_i), .use_rs2_i(use_rs2_i),
    .rd_tag_old_i(rd_tag_old_i), .rd_addr_i(rd_addr_i), .rd_we_i(rd_we_i),
    .multicycle_i(multicycle_i), .ex_done_i(ex_done_i), .flush_i(flush_i),
    .wb_ready_i(wb_ready_i), .res_valid_o(res_valid_o), .tag_we_o(tag_we_o),
    .tag_waddr_o(tag_waddr_o), .tag_wdata_o(tag_wdata_o), .cnt_clr_i(cnt_clr_i),
    .taint_cnt_o(taint_cnt_o)
  );

  typedef struct {
    logic [1:0] mode;
    logic       set;
    logic       set_tag;
    logic       rs1;
    logic       rs2;
    logic       use_rs2;
    logic       rd_old;
    logic [4:0] rd;
    logic       we;
    logic       exp_we;
    logic       exp_wd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge (input drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Move from drive point to sample point.
  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic r1, input logic r2, input logic u2,
                       input logic [4:0] rd, input logic mc);
    mode_i = m; rs1_tag_i = r1; rs2_tag_i = r2; use_rs2_i = u2;
    rd_addr_i = rd; rd_we_i = 1'b1; multicycle_i = mc;
    register_set_i = 1'b0; set_tag_i = 1'b0; rd_tag_old_i = 1'b0;
  endtask

  initial begin
    // mode set stag rs1 rs2 use old rd we exp_we exp_wd
    vecs[0] = '{2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b1}; // OR 1|0
    vecs[1] = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3,  1'b1, 1'b1, 1'b1}; // AND imm
    vecs[2] = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4,  1'b1, 1'b1, 1'b0}; // CLEAR
    vecs[3] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6,  1'b1, 1'b1, 1'b1}; // OLD
    vecs[4] = '{2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8,  1'b1, 1'b1, 1'b0}; // AND 1&0
    vecs[5] = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd11, 1'b1, 1'b1, 1'b0}; // OR imm ignores rs2
    vecs[6] = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b1}; // set beats CLEAR
    vecs[7] = '{2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd13, 1'b1, 1'b1, 1'b0}; // set 0 beats OR
    vecs[8] = '{2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b1}; // rd=0
    vecs[9] = '{2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7,  1'b0, 1'b0, 1'b1}; // no rd_we

    // Reset state.
    step(); step();
    settle();
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_tag_we", tag_we_o, 0);
    chk("rst_waddr", tag_waddr_o, 0);
    chk("rst_wdata", tag_wdata_o, 0);
    chk("rst_cnt", taint_cnt_o, 0);
    step(); rst = 1'b0; settle();
    chk("post_rst_ready", ex_ready_o, 1);

    // Table of single-cycle instructions.
    for (int i = 0; i < 10; i++) begin
      step();
      mode_i = vecs[i].mode; register_set_i = vecs[i].set; set_tag_i = vecs[i].set_tag;
      rs1_tag_i = vecs[i].rs1; rs2_tag_i = vecs[i].rs2; use_rs2_i = vecs[i].use_rs2;
      rd_tag_old_i = vecs[i].rd_old; rd_addr_i = vecs[i].rd; rd_we_i = vecs[i].we;
      multicycle_i = 1'b0; wb_ready_i = 1'b1; id_valid_i = 1'b1;
      settle();
      chk($sformatf("v%0d_ready", i), ex_ready_o, 1);
      step();
      id_valid_i = 1'b0;
      settle();
      chk($sformatf("v%0d_res_valid", i), res_valid_o, 1);
      chk($sformatf("v%0d_tag_we", i), tag_we_o, vecs[i].exp_we);
      chk($sformatf("v%0d_waddr", i), tag_waddr_o, vecs[i].rd);
      chk($sformatf("v%0d_wdata", i), tag_wdata_o, vecs[i].exp_wd);
      if (vecs[i].exp_we && vecs[i].exp_wd) model_cnt++;
      step();
      settle();
      chk($sformatf("v%0d_idle", i), res_valid_o, 0);
      chk($sformatf("v%0d_cnt", i), taint_cnt_o, model_cnt);
    end

    // Multicycle op: ex_done four cycles after accept, then backpressure for 3 cycles.
    step();
    drive(2'b10, 1'b1, 1'b0, 1'b1, 5'd9, 1'b1);
    id_valid_i = 1'b1;
    step();
    id_valid_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) ex_done_i = 1'b1;
      settle();
      chk($sformatf("mc_hold%0d_ready", c), ex_ready_o, 0);
      chk($sformatf("mc_hold%0d_valid", c), res_valid_o, 0);
      step();
    end
    ex_done_i = 1'b0;
    wb_ready_i = 1'b0;
    drive(2'b11, 1'b1, 1'b1, 1'b1, 5'd10, 1'b0);
    id_valid_i = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      settle();
      chk($sformatf("bp%0d_valid", c), res_valid_o, 1);
      chk($sformatf("bp%0d_waddr", c), tag_waddr_o, 9);
      chk($sformatf("bp%0d_wdata", c), tag_wdata_o, 1);
      chk($sformatf("bp%0d_ready", c), ex_ready_o, 0);
      chk($sformatf("bp%0d_cnt", c), taint_cnt_o, model_cnt);
      step();
    end
    wb_ready_i = 1'b1;
    settle();
    chk("bp_release_ready", ex_ready_o, 1);
    step();
    id_valid_i = 1'b0;
    model_cnt++;
    settle();
    chk("b2b_cnt", taint_cnt_o, model_cnt);
    chk("b2b_valid", res_valid_o, 1);
    chk("b2b_waddr", tag_waddr_o, 10);
    chk("b2b_wdata", tag_wdata_o, 0);
    step();
    settle();
    chk("b2b_done_valid", res_valid_o, 0);
    chk("b2b_done_cnt", taint_cnt_o, model_cnt);

    // Flush together with id_valid.
    step();
    drive(2'b10, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0);
    id_valid_i = 1'b1; flush_i = 1'b1;
    step();
    id_valid_i = 1'b0; flush_i = 1'b0;
    settle();
    chk("flush_id_valid", res_valid_o, 0);
    chk("flush_id_we", tag_we_o, 0);
    step();
    settle();
    chk("flush_id_cnt", taint_cnt_o, model_cnt);

    // Flush while in HOLD; a later ex_done must not revive it.
    step();
    drive(2'b10, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
    id_valid_i = 1'b1;
    step();
    id_valid_i = 1'b0; flush_i = 1'b1;
    step();
    flush_i = 1'b0; ex_done_i = 1'b1;
    settle();
    chk("flush_hold_valid", res_valid_o, 0);
    chk("flush_hold_ready", ex_ready_o, 1);
    step();
    ex_done_i = 1'b0;
    settle();
    chk("flush_hold_done_ignored", res_valid_o, 0);
    chk("flush_hold_we", tag_we_o, 0);
    chk("flush_hold_cnt", taint_cnt_o, model_cnt);

    // Reset while a result is pending drops it and clears the counter.
    step();
    drive(2'b10, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0);
    wb_ready_i = 1'b0; id_valid_i = 1'b1;
    step();
    id_valid_i = 1'b0;
    settle();
    chk("pre_rst_valid", res_valid_o, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; wb_ready_i = 1'b1;
    model_cnt = 0;
    settle();
    chk("midrst_valid", res_valid_o, 0);
    chk("midrst_ready", ex_ready_o, 1);
    chk("midrst_waddr", tag_waddr_o, 0);
    chk("midrst_cnt", taint_cnt_o, 0);

    // Saturation: back-to-back tainted writes until the counter pins at FFFF.
    step();
    drive(2'b10, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0);
    id_valid_i = 1'b1;
    for (int n = 0; n < 65537; n++) step();
    settle();
    chk("sat_cnt", taint_cnt_o, 16'hFFFF);
    chk("sat_we", tag_we_o, 1);
    step();
    id_valid_i = 1'b0;
    settle();
    chk("sat_hold_cnt", taint_cnt_o, 16'hFFFF);
    step();
    settle();
    chk("sat_idle", res_valid_o, 0);

    // Clear together with a completing tainted write.
    drive(2'b10, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0);
    id_valid_i = 1'b1;
    step();
    id_valid_i = 1'b0; cnt_clr_i = 1'b1;
    settle();
    chk("clr_we", tag_we_o, 1);
    step();
    cnt_clr_i = 1'b0;
    settle();
    chk("clr_cnt", taint_cnt_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_tag_prop_ex.md
RISCV_TAG_PROP_EX -- requirements
Module: riscv_tag_prop_ex

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL declare parameter ALU_MODE_WIDTH, default 2, the mode field width from riscv_defines.
REQ-003 SHALL use mode encoding ALU_MODE_OLD=00, ALU_MODE_AND=01, ALU_MODE_OR=10, ALU_MODE_CLEAR=11.
REQ-004 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  core clock
- rst  in  1  sync reset, active-high
- id_valid_i  in  1  ID presents instruction
- ex_ready_o  out  1  block accepts instruction this cycle
- mode_i  in  ALU_MODE_WIDTH  propagation mode from ID mode decoder
- register_set_i  in  1  tag-set instruction
- set_tag_i  in  1  tag value for tag-set
- rs1_tag_i, rs2_tag_i  in  1 each  source operand tags
- use_rs2_i  in  1  rs2 is a real operand, not an immediate
- rd_tag_old_i  in  1  current destination tag
- rd_addr_i  in  5  destination register
- rd_we_i  in  1  instruction writes rd
- multicycle_i  in  1  MUL/DIV multicycle op
- ex_done_i  in  1  multicycle unit finished
- flush_i  in  1  kill in-flight instruction
- wb_ready_i  in  1  tag register file accepts result
- res_valid_o  out  1  result pending
- tag_we_o  out  1  tag write enable
- tag_waddr_o  out  5  tag write address
- tag_wdata_o  out  1  tag write data
- cnt_clr_i  in  1  clear taint counter
- taint_cnt_o  out  16  tainted-write counter

Function
REQ-005 SHALL implement FSM states IDLE, HOLD, OUT.
REQ-006 SHALL drive ex_ready_o = (IDLE) | (OUT & wb_ready_i); ex_ready_o SHALL be 0 in HOLD.
REQ-007 SHALL accept an instruction when id_valid_i & ex_ready_o & !flush_i, capturing all ID inputs.
REQ-008 SHALL enter HOLD on accept when multicycle_i=1, otherwise OUT; res_valid_o SHALL rise the cycle after accept.
REQ-009 SHALL move from HOLD to OUT on ex_done_i; res_valid_o SHALL rise the following cycle. ex_done_i outside HOLD SHALL be ignored.
REQ-010 SHALL compute the result tag:
- register_set=1: set_tag (overrides mode)
- OLD: rd_tag_old
- AND: rs1 & (use_rs2 ? rs2 : 1)
- OR: rs1 | (use_rs2 ? rs2 : 0)
- CLEAR: 0
REQ-011 SHALL drive tag_we_o = res_valid_o & rd_we & (rd_addr != 0).
REQ-012 SHALL hold res_valid_o and the tag_* outputs stable while res_valid_o & !wb_ready_i.
REQ-013 SHALL complete the handshake on res_valid_o & wb_ready_i; the next state SHALL be IDLE, or HOLD/OUT if a new instruction is accepted in the same cycle (back-to-back, no bubble).
REQ-014 SHALL on flush_i return to IDLE, deassert res_valid_o next cycle, write nothing, and leave the counter unchanged; flush SHALL win over a simultaneous accept or completion.
REQ-015 SHALL increment taint_cnt_o by 1 on each completed handshake with tag_we_o=1 and tag_wdata_o=1, saturating at 16'hFFFF.
REQ-016 SHALL let cnt_clr_i zero the counter next cycle, overriding a simultaneous increment.

Reset
REQ-017 SHALL on rst force IDLE, res_valid_o=0, tag_we_o=0, tag_waddr_o=0, tag_wdata_o=0, and taint_cnt_o=0.
REQ-018 SHALL let rst mid-operation (HOLD or OUT) drop the instruction with no write; ex_ready_o=1 the cycle after reset deasserts.

Verification
REQ-019 SHALL cover: OR mode, rs1=1, rs2=0, use_rs2=1, rd=5, wb_ready=1 -> one cycle later tag_we=1, waddr=5, wdata=1, and taint_cnt=1.
REQ-020 SHALL cover: AND mode, rs1=1, use_rs2=0 -> wdata=1; CLEAR mode -> wdata=0; OLD mode with rd_tag_old=1 -> wdata=1.
REQ-021 SHALL cover: multicycle DIV, ex_done asserted 4 cycles after accept -> ex_ready=0 for those cycles and res_valid rising the cycle after ex_done.
REQ-022 SHALL cover: wb_ready=0 for 3 cycles -> outputs stable, no new accept, and exactly one counter increment when wb_ready rises.
REQ-023 SHALL cover: flush in the same cycle as id_valid, and flush in HOLD -> no tag_we and counter unchanged.
REQ-024 SHALL cover: counter preloaded to FFFF plus one tainted write -> stays FFFF; cnt_clr together with a tainted write -> 0; rd=0 -> tag_we=0 and no increment.
